fetch_stage: RTL

Instruction-fetch stage of the MIPS pipeline. It owns the program counter, drives the word address into the asynchronous-read instruction memory, and captures the returned instruction into the IF/ID pipeline register. Next-PC selection covers sequential, branch, jump and jump-register redirects, plus stall and flush control from the hazard unit.

---
 rtl/mips_pkg.sv | 15 +
 rtl/fetch_stage_next_pc_sel.sv | 45 ++++
 rtl/fetch_stage.sv | 87 ++++++++
 3 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared constants for the MIPS pipeline fetch path.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

    localparam int              c_DATA_WIDTH = 32;
    localparam int              c_JUMP_IDX_W = 26;
    localparam logic [31:0]     c_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0]     c_NOP_WORD   = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_next_pc_sel.sv
`default_nettype none
// ============================================================================
//  Module      : next_pc_sel
//  Description : Priority mux for the next word-address PC (jr > jump > branch > +1).
//  Revision    : 1.0  initial release
// ============================================================================
module next_pc_sel
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0]   pc,
    input  logic                    jr,
    input  logic [DATA_WIDTH-1:0]   jr_target,
    input  logic                    jump,
    input  logic [c_JUMP_IDX_W-1:0] jump_index,
    input  logic                    branch_taken,
    input  logic [DATA_WIDTH-1:0]   branch_target,
    output logic [DATA_WIDTH-1:0]   next_pc,
    output logic [DATA_WIDTH-1:0]   pc_plus1
);

    logic [DATA_WIDTH-1:0] w_pc_plus1;
    logic [DATA_WIDTH-1:0] w_jump_target;

    // Word-addressed memory: sequential step is one word.
    assign w_pc_plus1    = pc + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    // Jump region comes from the incremented PC, as in the MIPS J-format.
    assign w_jump_target = {w_pc_plus1[DATA_WIDTH-1:c_JUMP_IDX_W], jump_index};

    always_comb begin
        next_pc = w_pc_plus1;
        if (jr) begin
            next_pc = jr_target;
        end else if (jump) begin
            next_pc = w_jump_target;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end
    end

    assign pc_plus1 = w_pc_plus1;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch: PC register, next-PC selection, IF/ID register.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_stage
    import mips_pkg::*;
#(
    parameter int                    DATA_WIDTH = c_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = c_RESET_PC,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = c_NOP_WORD
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    branch_taken,
    input  logic [DATA_WIDTH-1:0]   branch_target,
    input  logic                    jump,
    input  logic [c_JUMP_IDX_W-1:0] jump_index,
    input  logic                    jr,
    input  logic [DATA_WIDTH-1:0]   jr_target,
    input  logic [DATA_WIDTH-1:0]   instr_in,
    output logic [DATA_WIDTH-1:0]   pc_out,
    output logic [DATA_WIDTH-1:0]   ifid_instr,
    output logic [DATA_WIDTH-1:0]   ifid_pc_next,
    output logic                    ifid_valid
);

    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_ifid_instr;
    logic [DATA_WIDTH-1:0] r_ifid_pc_next;
    logic                  r_ifid_valid;

    logic [DATA_WIDTH-1:0] w_next_pc;
    logic [DATA_WIDTH-1:0] w_pc_plus1;
    logic                  w_redirect;

    next_pc_sel #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_next_pc_sel (
        .pc            (r_pc),
        .jr            (jr),
        .jr_target     (jr_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .next_pc       (w_next_pc),
        .pc_plus1      (w_pc_plus1)
    );

    assign w_redirect = jr | jump | branch_taken;

    // A redirect must land even while the hazard unit is stalling.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc <= RESET_PC;
        end else if (w_redirect || !stall) begin
            r_pc <= w_next_pc;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ifid_instr   <= NOP_WORD;
            r_ifid_pc_next <= '0;
            r_ifid_valid   <= 1'b0;
        end else if (flush) begin
            r_ifid_instr   <= NOP_WORD;
            r_ifid_pc_next <= '0;
            r_ifid_valid   <= 1'b0;
        end else if (!stall) begin
            r_ifid_instr   <= instr_in;
            r_ifid_pc_next <= w_pc_plus1;
            r_ifid_valid   <= 1'b1;
        end
    end

    assign pc_out       = r_pc;
    assign ifid_instr   = r_ifid_instr;
    assign ifid_pc_next = r_ifid_pc_next;
    assign ifid_valid   = r_ifid_valid;

endmodule
`default_nettype wire
